// File: rtl/wac_cmd_sched.sv
// wac_cmd_sched: FIFO-fed command scheduler that applies {ctrlWord, confWord} to the WAC control block.
// Define WAC_SCHED_TIMEOUT_EN to bound ADC waits to TIMEOUT cycles.
module wac_cmd_sched #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned SETTLE  = 64,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_wr,
   input  logic [7:0]  cmd_word,
   input  logic [15:0] cmd_conf,
   output logic        cmd_full,
   output logic        cmd_empty,
   input  logic        readyAdc,
   input  logic        err_clr,
   output logic [7:0]  ctrlWord,
   output logic [15:0] confWord,
   output logic        ctrlEn,
   output logic        busy,
   output logic        done,
   output logic        ovf_err,
   output logic        timeout_err
);

   localparam int unsigned AW          = $clog2(DEPTH);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
   localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
   localparam logic [3:0]  MODE_ADC    = 4'h9;
`ifdef WAC_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

   state_e      state_q;
   logic [23:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [15:0] cnt_q;
   logic [7:0]  ctrl_word_q;
   logic [15:0] conf_word_q;
   logic        ctrl_en_q;
   logic        done_q;
   logic        ovf_err_q;
   logic        timeout_err_q;

   logic        push;
   logic        pop;
   logic        is_adc;
   logic        to_hit;
   logic        run_exit;
   logic [23:0] head;

   // Full/empty come straight from the registered pointers, so a write is
   // judged against the occupancy before any same-cycle pop.
   assign cmd_empty = (wr_ptr_q == rd_ptr_q);
   assign cmd_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      push     = cmd_wr && !cmd_full;
      pop      = (state_q == S_IDLE) && !cmd_empty;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      head     = mem_q[rd_ptr_q[AW-1:0]];
      is_adc   = (ctrl_word_q[3:0] == MODE_ADC);
      to_hit   = TO_EN && (state_q == S_RUN) && is_adc && !readyAdc && (cnt_q == TO_LAST);
      run_exit = 1'b0;
      if (state_q == S_RUN) begin
         if (is_adc) run_exit = readyAdc || to_hit;
         else        run_exit = (cnt_q == SETTLE_LAST);
      end
   end

   // NOTE: the FIFO storage has no reset; emptiness is defined by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_word, cmd_conf};
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ovf_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (err_clr)                ovf_err_q <= 1'b0;
         else if (cmd_wr && cmd_full) ovf_err_q <= 1'b1;
         if (err_clr)     timeout_err_q <= 1'b0;
         else if (to_hit) timeout_err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ctrl_word_q <= '0;
         conf_word_q <= '0;
         ctrl_en_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  ctrl_word_q <= head[23:16];
                  conf_word_q <= head[15:0];
                  state_q     <= S_LOAD;
               end
            end
            S_LOAD: begin
               cnt_q     <= '0;
               ctrl_en_q <= 1'b1;
               state_q   <= S_RUN;
            end
            S_RUN: begin
               // Saturating so a very long ADC wait can never alias a settle/timeout match.
               if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
               if (run_exit) begin
                  ctrl_en_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               ctrl_word_q <= '0;
               conf_word_q <= '0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ctrlWord    = ctrl_word_q;
   assign confWord    = conf_word_q;
   assign ctrlEn      = ctrl_en_q;
   assign done        = done_q;
   assign busy        = (state_q != S_IDLE);
   assign ovf_err     = ovf_err_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_wac_cmd_sched.sv
// Bench for wac_cmd_sched: directed scenarios plus randomized bursts checked against a command-level model.
// Build with WAC_SCHED_TIMEOUT_EN defined to exercise the bounded ADC wait.
module tb_wac_cmd_sched;

   localparam int DEPTH   = 8;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 16;
`ifdef WAC_SCHED_TIMEOUT_EN
   localparam bit TO_EN    = 1'b1;
   localparam int ADC_WAIT = 10;
`else
   localparam bit TO_EN    = 1'b0;
   localparam int ADC_WAIT = 100;
`endif

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        cmd_wr   = 1'b0;
   logic [7:0]  cmd_word = '0;
   logic [15:0] cmd_conf = '0;
   logic        readyAdc = 1'b0;
   logic        err_clr  = 1'b0;
   logic        cmd_full, cmd_empty, ctrlEn, busy, done, ovf_err, timeout_err;
   logic [7:0]  ctrlWord;
   logic [15:0] confWord;

   wac_cmd_sched #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_word(cmd_word), .cmd_conf(cmd_conf),
      .cmd_full(cmd_full), .cmd_empty(cmd_empty), .readyAdc(readyAdc), .err_clr(err_clr),
      .ctrlWord(ctrlWord), .confWord(confWord), .ctrlEn(ctrlEn), .busy(busy), .done(done),
      .ovf_err(ovf_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  word;
      logic [15:0] conf;
      int          width;
      int          start_c;
      int          end_c;
      logic        done_seen;
      logic        stable;
   } win_t;

   win_t obs_q[$];
   win_t exp_q[$];
   win_t cur;
   bit   in_win    = 1'b0;
   int   cyc       = 0;
   int   done_cnt  = 0;
   int   adc_delay = 0;
   bit   adc_hold  = 1'b0;
   int   n_checks  = 0;
   int   n_errors  = 0;

   // Window monitor and ADC responder: records every ctrlEn window and raises
   // readyAdc once an ADC window has been open for adc_delay+1 cycles.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         in_win   = 1'b0;
         readyAdc = adc_hold;
      end else begin
         if (done === 1'b1) done_cnt++;
         if (ctrlEn === 1'b1) begin
            if (!in_win) begin
               in_win      = 1'b1;
               cur.word    = ctrlWord;
               cur.conf    = confWord;
               cur.width   = 1;
               cur.start_c = cyc;
               cur.stable  = 1'b1;
            end else begin
               cur.width++;
               if (ctrlWord !== cur.word || confWord !== cur.conf) cur.stable = 1'b0;
            end
         end else if (in_win) begin
            in_win        = 1'b0;
            cur.end_c     = cyc;
            cur.done_seen = done;
            if (ctrlWord !== cur.word || confWord !== cur.conf) cur.stable = 1'b0;
            obs_q.push_back(cur);
         end
         if (adc_hold) readyAdc = 1'b1;
         else if (in_win && cur.word[3:0] == 4'h9 && adc_delay >= 0 && cur.width >= adc_delay + 1)
            readyAdc = 1'b1;
         else readyAdc = 1'b0;
      end
   end

   // Model: how long ctrlEn should stay high for a command, -1 when not determined.
   function automatic int exp_width(input logic [7:0] w, input int delay);
      if (w[3:0] != 4'h9) return SETTLE;
      if (delay < 0) return TO_EN ? TIMEOUT : -1;
      if (TO_EN && delay + 1 > TIMEOUT) return TIMEOUT;
      return delay + 1;
   endfunction

   task automatic expect_cmd(input logic [7:0] w, input logic [15:0] c, input int width);
      win_t e;
      e.word  = w;
      e.conf  = c;
      e.width = width;
      exp_q.push_back(e);
   endtask

   task automatic push(input logic [7:0] w, input logic [15:0] c);
      @(negedge clk);
      cmd_wr   = 1'b1;
      cmd_word = w;
      cmd_conf = c;
      @(posedge clk);
      #1 cmd_wr = 1'b0;
   endtask

   task automatic pulse_err_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
   endtask

   task automatic wait_windows(input int n, input int budget);
      int k = 0;
      while (obs_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      #1;
      n_checks++;
      if (obs_q.size() < n) begin
         n_errors++;
         $display("FAIL wait_windows: got %0d ctrlEn windows, expected %0d within %0d cycles",
                  obs_q.size(), n, budget);
      end
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (!(busy === 1'b0 && cmd_empty === 1'b1) && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (!(busy === 1'b0 && cmd_empty === 1'b1)) begin
         n_errors++;
         $display("FAIL wait_idle: busy=%b cmd_empty=%b, expected busy=0 cmd_empty=1", busy, cmd_empty);
      end
   endtask

   task automatic drain(input string name);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_errors++;
         $display("FAIL %s count: got %0d windows, expected %0d", name, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i].word !== exp_q[i].word || obs_q[i].conf !== exp_q[i].conf ||
             (exp_q[i].width >= 0 && obs_q[i].width != exp_q[i].width) ||
             obs_q[i].done_seen !== 1'b1 || obs_q[i].stable !== 1'b1) begin
            n_errors++;
            $display("FAIL %s cmd%0d: got word=%h conf=%h width=%0d done=%b stable=%b, expected word=%h conf=%h width=%0d done=1 stable=1",
                     name, i, obs_q[i].word, obs_q[i].conf, obs_q[i].width, obs_q[i].done_seen,
                     obs_q[i].stable, exp_q[i].word, exp_q[i].conf, exp_q[i].width);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cmd_full, cmd_empty, ctrlEn, busy, done, ovf_err, timeout_err} !== 7'b0100000) begin
         n_errors++;
         $display("FAIL reset_flags: got full,empty,en,busy,done,ovf,to=%b expected 0100000",
                  {cmd_full, cmd_empty, ctrlEn, busy, done, ovf_err, timeout_err});
      end
      n_checks++;
      if ({ctrlWord, confWord} !== 24'h0) begin
         n_errors++;
         $display("FAIL reset_words: got %h expected 000000", {ctrlWord, confWord});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({cmd_empty, ctrlEn, busy, done} !== 4'b1000) begin
         n_errors++;
         $display("FAIL post_reset: got empty,en,busy,done=%b expected 1000", {cmd_empty, ctrlEn, busy, done});
      end
   endtask

   task automatic test_single_dac();
      int d0 = done_cnt;
      @(negedge clk);
      cmd_wr = 1'b1; cmd_word = 8'h01; cmd_conf = 16'h8000;
      @(posedge clk);
      #1 cmd_wr = 1'b0;
      n_checks++;
      if (cmd_empty !== 1'b0) begin
         n_errors++;
         $display("FAIL dac_empty_after_push: got %b expected 0", cmd_empty);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ctrlWord !== 8'h01 || confWord !== 16'h8000 || ctrlEn !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL dac_load: got word=%h conf=%h en=%b busy=%b expected 01 8000 0 1",
                  ctrlWord, confWord, ctrlEn, busy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ctrlEn !== 1'b1) begin
         n_errors++;
         $display("FAIL dac_run_start: got ctrlEn=%b expected 1", ctrlEn);
      end
      expect_cmd(8'h01, 16'h8000, SETTLE);
      wait_windows(1, 50);
      @(posedge clk);
      #1;
      n_checks++;
      if (ctrlWord !== 8'h00 || confWord !== 16'h0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL dac_back_idle: got word=%h conf=%h busy=%b expected 00 0000 0", ctrlWord, confWord, busy);
      end
      drain("single_dac");
      n_checks++;
      if (done_cnt - d0 != 1) begin
         n_errors++;
         $display("FAIL dac_done_count: got %0d expected 1", done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      int d0 = done_cnt;
      push(8'h02, 16'h0005); expect_cmd(8'h02, 16'h0005, SETTLE);
      push(8'h03, 16'h0210); expect_cmd(8'h03, 16'h0210, SETTLE);
      push(8'h04, 16'h0030); expect_cmd(8'h04, 16'h0030, SETTLE);
      wait_windows(3, 100);
      for (int i = 0; i + 1 < 3 && i + 1 < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i+1].start_c - obs_q[i].end_c != 3) begin
            n_errors++;
            $display("FAIL b2b_gap%0d: got %0d low cycles expected 3", i, obs_q[i+1].start_c - obs_q[i].end_c);
         end
      end
      wait_idle(20);
      n_checks++;
      if (cmd_empty !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_empty: got %b expected 1", cmd_empty);
      end
      drain("back_to_back");
      n_checks++;
      if (done_cnt - d0 != 3) begin
         n_errors++;
         $display("FAIL b2b_done_count: got %0d expected 3", done_cnt - d0);
      end
   endtask

   task automatic test_adc_wait();
      adc_delay = ADC_WAIT;
      push(8'h49, 16'h0000);
      expect_cmd(8'h49, 16'h0000, ADC_WAIT + 1);
      wait_windows(1, 300);
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_errors++;
         $display("FAIL adc_timeout_flag: got %b expected 0", timeout_err);
      end
      drain("adc_wait");
      adc_hold = 1'b1;
      push(8'h09, 16'h1234);
      expect_cmd(8'h09, 16'h1234, 1);
      wait_windows(1, 50);
      adc_hold = 1'b0;
      drain("adc_ready_on_entry");
      wait_idle(20);
   endtask

   task automatic test_overflow();
      int d0 = done_cnt;
      int k  = 0;
      logic [7:0]  w;
      logic [15:0] c;
      adc_delay = -1;
      push(8'h49, 16'hAAAA);
      expect_cmd(8'h49, 16'hAAAA, -1);
      while (ctrlEn !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (ctrlEn !== 1'b1) begin
         n_errors++;
         $display("FAIL ovf_adc_start: got ctrlEn=%b expected 1", ctrlEn);
      end
      for (int i = 0; i < 9; i++) begin
         w = 8'($urandom);
         if (w[3:0] == 4'h9) w[3:0] = 4'h1;
         c = 16'($urandom);
         push(w, c);
         if (i < DEPTH) expect_cmd(w, c, SETTLE);
      end
      n_checks++;
      if (ovf_err !== 1'b1 || cmd_full !== 1'b1) begin
         n_errors++;
         $display("FAIL ovf_flags: got ovf_err=%b cmd_full=%b expected 1 1", ovf_err, cmd_full);
      end
      pulse_err_clr();
      n_checks++;
      if (ovf_err !== 1'b0) begin
         n_errors++;
         $display("FAIL ovf_clear: got ovf_err=%b expected 0", ovf_err);
      end
      adc_delay = 0;
      wait_windows(DEPTH + 1, 300);
      wait_idle(20);
      drain("overflow");
      n_checks++;
      if (done_cnt - d0 != DEPTH + 1) begin
         n_errors++;
         $display("FAIL ovf_done_count: got %0d expected %0d", done_cnt - d0, DEPTH + 1);
      end
   endtask

   task automatic test_timeout();
      pulse_err_clr();
      adc_delay = -1;
      push(8'h89, 16'h0000);
`ifdef WAC_SCHED_TIMEOUT_EN
      expect_cmd(8'h89, 16'h0000, TIMEOUT);
      wait_windows(1, 100);
      n_checks++;
      if (timeout_err !== 1'b1) begin
         n_errors++;
         $display("FAIL timeout_set: got timeout_err=%b expected 1", timeout_err);
      end
      drain("timeout");
      pulse_err_clr();
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_errors++;
         $display("FAIL timeout_clear: got timeout_err=%b expected 0", timeout_err);
      end
`else
      repeat (1000) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || ctrlEn !== 1'b1 || timeout_err !== 1'b0 || obs_q.size() != 0) begin
         n_errors++;
         $display("FAIL unbounded_wait: got busy=%b ctrlEn=%b timeout_err=%b windows=%0d expected 1 1 0 0",
                  busy, ctrlEn, timeout_err, obs_q.size());
      end
      adc_delay = 0;
      expect_cmd(8'h89, 16'h0000, -1);
      wait_windows(1, 20);
      drain("unbounded_wait_release");
`endif
      wait_idle(20);
   endtask

   task automatic test_reset_mid();
      int d0 = done_cnt;
      int k  = 0;
      push(8'h01, 16'h1111);
      push(8'h05, 16'h2222);
      while (ctrlEn !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (ctrlEn !== 1'b0 || busy !== 1'b0 || cmd_empty !== 1'b1 || ctrlWord !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_mid_async: got ctrlEn=%b busy=%b empty=%b word=%h expected 0 0 1 00",
                  ctrlEn, busy, cmd_empty, ctrlWord);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (done_cnt != d0 || obs_q.size() != 0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_quiet: got done pulses=%0d windows=%0d busy=%b expected 0 0 0",
                  done_cnt - d0, obs_q.size(), busy);
      end
      push(8'h03, 16'h3333);
      expect_cmd(8'h03, 16'h3333, SETTLE);
      wait_windows(1, 50);
      drain("reset_mid_recover");
      wait_idle(20);
   endtask

   task automatic test_random();
      logic [7:0]  w;
      logic [15:0] c;
      for (int b = 0; b < 4; b++) begin
         int n  = int'($urandom_range(1, DEPTH));
         int d0 = done_cnt;
         adc_delay = int'($urandom_range(0, 12));
         for (int i = 0; i < n; i++) begin
            w = 8'($urandom);
            if ($urandom_range(0, 3) == 0) w[3:0] = 4'h9;
            c = 16'($urandom);
            push(w, c);
            expect_cmd(w, c, exp_width(w, adc_delay));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wait_windows(n, 400);
         wait_idle(20);
         drain("random");
         n_checks++;
         if (done_cnt - d0 != n) begin
            n_errors++;
            $display("FAIL random_done_count: got %0d expected %0d", done_cnt - d0, n);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_dac();
      test_back_to_back();
      test_adc_wait();
      test_overflow();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/wac_cmd_sched.md
# wac_cmd_sched

Command scheduler in front of the WAC control block. Accepts a queue of {ctrlWord, confWord} commands from the host interface and drives them into the control block one at a time. For each command it applies the words, asserts the enable, and waits either a fixed settle time (DAC, digipot, mux, sequencer) or for ADC completion. Back-to-back configuration sequences such as "set refs → load DAC → set digipot → acquire ADC1" run without host polling.

## Interface

**Parameters**
- `DEPTH`, default 8: FIFO entries. Must be a power of 2, ≥2.
- `SETTLE`, default 64: cycles ctrlEn is held for non-ADC commands. Range 1..65535.
- `TIMEOUT`, default 65535: maximum cycles to wait for readyAdc. Used only with `WAC_SCHED_TIMEOUT_EN`.

**Ports** (name, direction, width, meaning)
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_wr` in 1: push {cmd_word, cmd_conf} into the FIFO when high for one cycle.
- `cmd_word` in 8: ctrlWord field. [3:0] is the mode code; [7:6] selects the ADC.
- `cmd_conf` in 16: confWord field.
- `cmd_full` out 1: FIFO holds DEPTH entries.
- `cmd_empty` out 1: FIFO holds 0 entries.
- `readyAdc` in 1: ADC completion from the control block, sampled as a level.
- `err_clr` in 1: clears `ovf_err` and `timeout_err`.
- `ctrlWord` out 8: to the control block.
- `confWord` out 16: to the control block.
- `ctrlEn` out 1: to the control block.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: one-cycle pulse per completed command.
- `ovf_err` out 1: sticky. Set when a write arrives while full.
- `timeout_err` out 1: sticky. Set when an ADC wait expires.

## Operation

**FIFO**
- Width 24 bits, data = {cmd_word, cmd_conf}.
- Circular buffer with read/write pointers of log2(DEPTH)+1 bits. Pointers wrap naturally.
- `cmd_full` is evaluated before any same-cycle pop. A write while `cmd_full`=1 is dropped and sets `ovf_err`, even if the FSM pops in the same cycle.
- A write while empty, coincident with nothing else, is accepted normally.

**FSM states: IDLE, LOAD, RUN, DONE**
- **IDLE**: ctrlWord=8'h00, confWord=0, ctrlEn=0. If `!cmd_empty`, pop the head entry into the holding registers and go to LOAD.
- **LOAD**: ctrlWord/confWord = held entry, ctrlEn=0. This gives one setup cycle. Clear the wait counter. Go to RUN.
- **RUN**: ctrlWord/confWord held, ctrlEn=1, counter increments each cycle.
  - ADC command (word[3:0]==4'h9): exit to DONE on the first cycle `readyAdc`=1. A `readyAdc` already high on RUN entry counts.
  - Any other code, including 4'h2 (mux), 4'h4 (sequencer), and undefined codes: exit to DONE when counter == SETTLE-1.
- **DONE**: ctrlEn=0, ctrlWord/confWord still held, `done`=1. Go to IDLE.

**Status and errors**
- `busy` = (state != IDLE).
- `err_clr` has priority over a same-cycle error set; the clear wins.
- Counter is 16 bits and saturates; it never wraps.

**Reset**
- Asynchronous. All outputs go to 0, `cmd_empty`=1, state=IDLE, pointers=0, FIFO contents discarded.
- A reset during RUN drops ctrlEn immediately and does not produce `done`.

## Timing

- Push at edge E: `cmd_empty`=0 after E.
- If IDLE, the pop occurs at E+1 (state→LOAD, ctrlWord valid after E+1). RUN starts with ctrlEn=1 after E+2.
- Non-ADC command: ctrlEn high for exactly SETTLE cycles. DONE (done=1) after edge E+2+SETTLE. IDLE with ctrlWord=0 after E+3+SETTLE.
- ADC command with readyAdc sampled high at edge R: DONE after R. Minimum ctrlEn width is 1 cycle.
- Per-command overhead beyond ctrlEn width: 3 cycles (IDLE/LOAD/DONE). The next command's LOAD follows DONE+IDLE with no further gap.
- `cmd_full`/`cmd_empty` are registered-pointer comparisons and update the cycle after the causing edge.

## Configuration

`WAC_SCHED_TIMEOUT_EN`:
- **Defined**: in RUN for an ADC command, if counter reaches TIMEOUT-1 without `readyAdc`, set `timeout_err` and go to DONE. `done` still pulses.
- **Undefined**: ADC waits are unbounded; `timeout_err` is constant 0 and the TIMEOUT parameter is ignored.

## Test plan

- **Single DAC command.** Reset, then push {8'h01,16'h8000} with SETTLE=4.
  - ctrlWord=01 and confWord=8000 two edges after the push.
  - ctrlEn high for exactly 4 cycles, one `done` pulse, then ctrlWord=00 and busy=0.
- **Queue of 3 with ordering.** Push 02/0005, 03/0210, 04/0030 back-to-back.
  - Issued in order, 3 `done` pulses.
  - 3-cycle gaps between ctrlEn windows; `cmd_empty`=1 at the end.
- **ADC wait.** Push 8'h49/0. Hold readyAdc low for 100 cycles, then high 1 cycle.
  - ctrlEn high for 101 cycles; `done` the next cycle; `timeout_err`=0.
- **Overflow.** With DEPTH=8 and the FSM busy on a long ADC command, push 9 entries while readyAdc stays low.
  - 9th push dropped, `ovf_err`=1, `cmd_full`=1.
  - After err_clr, `ovf_err`=0 and the 8 queued entries still execute in order.
- **Timeout.** With `WAC_SCHED_TIMEOUT_EN` defined and TIMEOUT=16, push 8'h89 with readyAdc never asserted.
  - ctrlEn high for 16 cycles, `timeout_err`=1, `done` pulses.
  - Without the macro, the FSM is still in RUN after 1000 cycles.
- **Reset mid-command.** Assert rst during RUN of a DAC command.
  - ctrlEn=0 asynchronously, no `done`, FIFO empty.
  - After release, a new push executes normally.
